// File: rtl/mvb_rr_merge.sv
// rtl/mvb_rr_merge.sv - round-robin merge of several MVB streams into one registered output
// Grants whole words from one stream at a time, rotating after MAX_BURST transfers or when idle.
module mvb_rr_merge #(
  parameter int RX_STREAMS     = 4,
  parameter int MVB_ITEMS      = 4,
  parameter int MVB_ITEM_WIDTH = 32,
  parameter int MAX_BURST      = 4
) (
  input  logic                                            CLK,
  input  logic                                            RESET,
  input  logic [RX_STREAMS*MVB_ITEMS*MVB_ITEM_WIDTH-1:0] RX_DATA,
  input  logic [RX_STREAMS*MVB_ITEMS-1:0]                RX_VLD,
  input  logic [RX_STREAMS-1:0]                          RX_SRC_RDY,
  output logic [RX_STREAMS-1:0]                          RX_DST_RDY,
  output logic [MVB_ITEMS*MVB_ITEM_WIDTH-1:0]            TX_DATA,
  output logic [MVB_ITEMS-1:0]                           TX_VLD,
  output logic                                           TX_SRC_RDY,
  input  logic                                           TX_DST_RDY,
  output logic [$clog2(RX_STREAMS)-1:0]                  TX_SEL
);

  localparam int SW = $clog2(RX_STREAMS);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int WW = MVB_ITEMS * MVB_ITEM_WIDTH;
  localparam logic [CW-1:0] C_LAST = CW'(MAX_BURST - 1);

  logic [SW-1:0]        g_q, g_d;
  logic [CW-1:0]        c_q, c_d;
  logic [WW-1:0]        data_q, data_d;
  logic [MVB_ITEMS-1:0] vld_q, vld_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic                 rdy_q, rdy_d;

  logic                 load_ok, xfer, g_req;
  logic [WW-1:0]        rx_word;
  logic [MVB_ITEMS-1:0] rx_vld;
  logic                 any_hi, any_lo;
  logic [SW-1:0]        hi_idx, lo_idx, g_next;

  assign load_ok = !rdy_q || TX_DST_RDY;
  assign xfer    = g_req && load_ok;

  always_comb begin
    rx_word = '0;
    rx_vld  = '0;
    g_req   = 1'b0;
    for (int i = 0; i < RX_STREAMS; i++) begin
      if (g_q == SW'(i)) begin
        rx_word = RX_DATA[i*WW +: WW];
        rx_vld  = RX_VLD[i*MVB_ITEMS +: MVB_ITEMS];
        g_req   = RX_SRC_RDY[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RX_STREAMS; i++) begin
      RX_DST_RDY[i] = (g_q == SW'(i)) && load_ok && !RESET;
    end
  end

  // Lowest requester above G wins; otherwise lowest at or below G, so G itself comes last.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = RX_STREAMS - 1; i >= 0; i--) begin
      if (RX_SRC_RDY[i]) begin
        if (SW'(i) > g_q) begin
          any_hi = 1'b1;
          hi_idx = SW'(i);
        end else begin
          any_lo = 1'b1;
          lo_idx = SW'(i);
        end
      end
    end
    g_next = any_hi ? hi_idx : (any_lo ? lo_idx : g_q);
  end

  always_comb begin
    g_d    = g_q;
    c_d    = c_q;
    data_d = data_q;
    vld_d  = vld_q;
    sel_d  = sel_q;
    rdy_d  = rdy_q;
    if (TX_DST_RDY) rdy_d = 1'b0;
    if (xfer) begin
      // Words with no valid item are consumed here but never reach the output.
      if (|rx_vld) begin
        data_d = rx_word;
        vld_d  = rx_vld;
        sel_d  = g_q;
        rdy_d  = 1'b1;
      end
      if (c_q == C_LAST) begin
        g_d = g_next;
        c_d = '0;
      end else begin
        c_d = c_q + 1'b1;
      end
    end else if (load_ok && (|RX_SRC_RDY)) begin
      g_d = g_next;
      c_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      g_q    <= '0;
      c_q    <= '0;
      data_q <= '0;
      vld_q  <= '0;
      sel_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      g_q    <= g_d;
      c_q    <= c_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      sel_q  <= sel_d;
      rdy_q  <= rdy_d;
    end
  end

  assign TX_DATA    = data_q;
  assign TX_VLD     = vld_q;
  assign TX_SEL     = sel_q;
  assign TX_SRC_RDY = rdy_q;

endmodule

// File: tb/tb_mvb_rr_merge.sv
// tb/tb_mvb_rr_merge.sv - self-checking bench for mvb_rr_merge
// Directed tables, hand sequences and a randomized per-stream scoreboard run.
module tb_mvb_rr_merge;

  localparam int N   = 4;
  localparam int IT  = 4;
  localparam int IW  = 32;
  localparam int WW  = IT * IW;
  localparam int CKW = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*WW-1:0] rx_data;
  logic [N*IT-1:0] rx_vld;
  logic [N-1:0]    rx_src_rdy;
  logic            tx_dst_rdy;
  logic [N-1:0]    dst0, dst1, dst;
  logic [WW-1:0]   txd0, txd1, txd;
  logic [IT-1:0]   txv0, txv1, txv;
  logic            txr0, txr1, txr;
  logic [1:0]      sel0, sel1, sel;
  logic            use1;

  mvb_rr_merge #(.RX_STREAMS(N), .MVB_ITEMS(IT), .MVB_ITEM_WIDTH(IW), .MAX_BURST(4)) dut0 (
    .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VLD(rx_vld), .RX_SRC_RDY(rx_src_rdy),
    .RX_DST_RDY(dst0), .TX_DATA(txd0), .TX_VLD(txv0), .TX_SRC_RDY(txr0),
    .TX_DST_RDY(tx_dst_rdy), .TX_SEL(sel0));

  mvb_rr_merge #(.RX_STREAMS(N), .MVB_ITEMS(IT), .MVB_ITEM_WIDTH(IW), .MAX_BURST(1)) dut1 (
    .CLK(clk), .RESET(rst), .RX_DATA(rx_data), .RX_VLD(rx_vld), .RX_SRC_RDY(rx_src_rdy),
    .RX_DST_RDY(dst1), .TX_DATA(txd1), .TX_VLD(txv1), .TX_SRC_RDY(txr1),
    .TX_DST_RDY(tx_dst_rdy), .TX_SEL(sel1));

  assign dst = use1 ? dst1 : dst0;
  assign txd = use1 ? txd1 : txd0;
  assign txv = use1 ? txv1 : txv0;
  assign txr = use1 ? txr1 : txr0;
  assign sel = use1 ? sel1 : sel0;

  typedef struct {
    logic [WW-1:0] d;
    logic [IT-1:0] v;
  } word_t;

  typedef struct {
    logic       tdr;
    logic       er;
    logic [1:0] es;
    logic [3:0] ed;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            seq[N];
  int            rem[N];
  logic [N-1:0]  gate;
  logic [3:0]    vq[N][$];
  logic [3:0]    cur_vld[N];
  bit            rand_mode;
  word_t         expq[N][$];
  logic [N-1:0]  consumed;
  logic          prev_stall;
  logic [WW+IT+2:0] prev_tx;
  bit            run_chk;
  int            run_sel, run_len;
  vec_t          tv[18];

  task automatic chk(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkword(input int s, input int q);
    logic [WW-1:0] w;
    for (int j = 0; j < IT; j++) w[j*IW +: IW] = {4'(s), 4'(j), 24'(q)};
    return w;
  endfunction

  function automatic logic [3:0] nextv(input int i);
    if (vq[i].size() > 0) return vq[i][0];
    if (rand_mode) return 4'($urandom_range(0, 15));
    return 4'hF;
  endfunction

  function automatic vec_t mk(input logic a, input logic b, input logic [1:0] c, input logic [3:0] d);
    vec_t t;
    t.tdr = a; t.er = b; t.es = c; t.ed = d;
    return t;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      rx_data[i*WW +: WW] = mkword(i, seq[i]);
      rx_vld[i*IT +: IT]  = cur_vld[i];
      rx_src_rdy[i]       = (rem[i] > 0) && gate[i];
    end
  endtask

  task automatic setup_done();
    for (int i = 0; i < N; i++) cur_vld[i] = nextv(i);
    apply();
  endtask

  // Observe one cycle just before its active edge: scoreboard, one-hot grant, stall stability.
  task automatic sample();
    word_t w;
    @(negedge clk);
    chk("dst_onehot", CKW'($countones(dst) <= 1), CKW'(1));
    if (prev_stall) chk("tx_stable", CKW'({txd, txv, sel, txr}), CKW'(prev_tx));
    if (txr && tx_dst_rdy) begin
      checks++;
      if (expq[sel].size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: stream %0d word %0h expected none", sel, txd);
      end else begin
        w = expq[sel].pop_front();
        chk("sb_data", CKW'(txd), CKW'(w.d));
        chk("sb_vld", CKW'(txv), CKW'(w.v));
      end
      if (run_chk) begin
        if (int'(sel) != run_sel) begin
          if (run_len > 0) chk("burst_len", CKW'(run_len), CKW'(4));
          run_sel = int'(sel);
          run_len = 1;
        end else begin
          run_len++;
        end
      end
    end
    consumed = rx_src_rdy & dst;
    for (int i = 0; i < N; i++) begin
      if (consumed[i] && cur_vld[i] != 4'h0) begin
        w.d = mkword(i, seq[i]);
        w.v = cur_vld[i];
        expq[i].push_back(w);
      end
    end
    prev_stall = txr && !tx_dst_rdy;
    prev_tx    = {txd, txv, sel, txr};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (consumed[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
        if (vq[i].size() > 0) void'(vq[i].pop_front());
        cur_vld[i] = nextv(i);
      end
    end
    apply();
  endtask

  task automatic do_reset(input logic which1);
    rst = 1'b1;
    use1 = which1;
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      vq[i].delete();
      seq[i] = 0;
      rem[i] = 0;
      cur_vld[i] = 4'hF;
    end
    gate = '1;
    rand_mode = 1'b0;
    tx_dst_rdy = 1'b1;
    prev_stall = 1'b0;
    run_chk = 1'b0;
    run_sel = -1;
    run_len = 0;
    consumed = '0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int er[11];
    int es[11];
    int pat[4];

    // Reset state and first grant
    do_reset(1'b0);
    setup_done();
    sample();
    chk("rst_txr", CKW'(txr), CKW'(0));
    chk("rst_txv", CKW'(txv), CKW'(0));
    chk("rst_txd", CKW'(txd), CKW'(0));
    chk("rst_sel", CKW'(sel), CKW'(0));
    chk("rst_dst", CKW'(dst), CKW'(4'b0001));
    advance();

    // Single stream 2, ten words, one idle cycle to rotate from G=0
    do_reset(1'b0);
    rem[2] = 10;
    setup_done();
    for (int cyc = 0; cyc < 14; cyc++) begin
      sample();
      if (cyc == 0) chk("s2_dst0", CKW'(dst), CKW'(4'b0001));
      if (cyc == 1) chk("s2_dst1", CKW'(dst), CKW'(4'b0100));
      chk("s2_valid", CKW'(txr), CKW'(cyc >= 2 && cyc <= 11));
      if (cyc >= 2 && cyc <= 11) begin
        chk("s2_sel", CKW'(sel), CKW'(2));
        chk("s2_seq", CKW'(txd[23:0]), CKW'(cyc - 2));
      end
      advance();
    end

    // All streams saturated: table of per-cycle expectations
    tv[0]  = mk(1'b1, 1'b0, 2'd0, 4'b0001);
    tv[1]  = mk(1'b1, 1'b1, 2'd0, 4'b0001);
    tv[2]  = mk(1'b1, 1'b1, 2'd0, 4'b0001);
    tv[3]  = mk(1'b1, 1'b1, 2'd0, 4'b0001);
    tv[4]  = mk(1'b1, 1'b1, 2'd0, 4'b0010);
    tv[5]  = mk(1'b1, 1'b1, 2'd1, 4'b0010);
    tv[6]  = mk(1'b1, 1'b1, 2'd1, 4'b0010);
    tv[7]  = mk(1'b1, 1'b1, 2'd1, 4'b0010);
    tv[8]  = mk(1'b1, 1'b1, 2'd1, 4'b0100);
    tv[9]  = mk(1'b1, 1'b1, 2'd2, 4'b0100);
    tv[10] = mk(1'b1, 1'b1, 2'd2, 4'b0100);
    tv[11] = mk(1'b1, 1'b1, 2'd2, 4'b0100);
    tv[12] = mk(1'b1, 1'b1, 2'd2, 4'b1000);
    tv[13] = mk(1'b1, 1'b1, 2'd3, 4'b1000);
    tv[14] = mk(1'b1, 1'b1, 2'd3, 4'b1000);
    tv[15] = mk(1'b1, 1'b1, 2'd3, 4'b1000);
    tv[16] = mk(1'b1, 1'b1, 2'd3, 4'b0001);
    tv[17] = mk(1'b1, 1'b1, 2'd0, 4'b0001);
    do_reset(1'b0);
    for (int i = 0; i < N; i++) rem[i] = 1000;
    setup_done();
    for (int n = 0; n < 18; n++) begin
      tx_dst_rdy = tv[n].tdr;
      sample();
      chk("sat_txr", CKW'(txr), CKW'(tv[n].er));
      if (tv[n].er) chk("sat_sel", CKW'(sel), CKW'(tv[n].es));
      chk("sat_dst", CKW'(dst), CKW'(tv[n].ed));
      advance();
    end

    // Backpressure 1,0,0,1: runs of four per stream, scoreboard per stream
    pat = '{1, 0, 0, 1};
    do_reset(1'b0);
    for (int i = 0; i < N; i++) rem[i] = 1000;
    run_chk = 1'b1;
    setup_done();
    for (int cyc = 0; cyc < 96; cyc++) begin
      tx_dst_rdy = pat[cyc % 4] != 0;
      sample();
      advance();
    end
    run_chk = 1'b0;

    // Empty word then 0101 from stream 1; both count toward the burst
    er = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    es = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    do_reset(1'b0);
    rem[1] = 6;
    vq[1].push_back(4'b0000);
    vq[1].push_back(4'b0101);
    setup_done();
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 1) begin
        rem[0] = 1000;
        apply();
      end
      sample();
      chk("ew_txr", CKW'(txr), CKW'(er[cyc]));
      if (er[cyc] != 0) chk("ew_sel", CKW'(sel), CKW'(es[cyc]));
      if (cyc == 3) chk("ew_vld", CKW'(txv), CKW'(4'b0101));
      if (cyc == 4) chk("ew_vld_full", CKW'(txv), CKW'(4'b1111));
      advance();
    end

    // MAX_BURST=1, streams 0 and 3 saturated
    do_reset(1'b1);
    rem[0] = 1000;
    rem[3] = 1000;
    setup_done();
    for (int cyc = 0; cyc < 16; cyc++) begin
      sample();
      chk("mb1_dst12", CKW'(dst[2:1]), CKW'(0));
      if (cyc >= 1) begin
        chk("mb1_txr", CKW'(txr), CKW'(1));
        chk("mb1_sel", CKW'(sel), CKW'((cyc % 2 == 1) ? 0 : 3));
      end
      advance();
    end

    // Reset while the output is stalled
    do_reset(1'b0);
    for (int i = 0; i < N; i++) rem[i] = 1000;
    setup_done();
    for (int cyc = 0; cyc < 6; cyc++) begin
      tx_dst_rdy = (cyc < 3);
      sample();
      advance();
    end
    chk("mr_pre_txr", CKW'(txr), CKW'(1));
    rst = 1'b1;
    #1;
    chk("mr_txr", CKW'(txr), CKW'(0));
    chk("mr_dst", CKW'(dst), CKW'(0));
    chk("mr_txv", CKW'(txv), CKW'(0));
    chk("mr_txd", CKW'(txd), CKW'(0));
    chk("mr_sel", CKW'(sel), CKW'(0));
    for (int i = 0; i < N; i++) expq[i].delete();
    prev_stall = 1'b0;
    consumed = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_dst_rdy = 1'b1;
    sample();
    chk("mr_post_dst", CKW'(dst), CKW'(4'b0001));
    advance();
    sample();
    chk("mr_post_txr", CKW'(txr), CKW'(1));
    chk("mr_post_sel", CKW'(sel), CKW'(0));
    advance();

    // Randomized traffic on both burst settings, then drain and check nothing is left
    for (int d = 0; d < 2; d++) begin
      do_reset(d == 1);
      rand_mode = 1'b1;
      for (int i = 0; i < N; i++) rem[i] = $urandom_range(50, 400);
      setup_done();
      for (int cyc = 0; cyc < 1500; cyc++) begin
        gate = N'($urandom);
        tx_dst_rdy = 1'($urandom);
        apply();
        sample();
        advance();
      end
      for (int i = 0; i < N; i++) rem[i] = 0;
      tx_dst_rdy = 1'b1;
      apply();
      for (int cyc = 0; cyc < 4; cyc++) begin
        sample();
        advance();
      end
      for (int i = 0; i < N; i++) chk("rnd_drained", CKW'(expq[i].size()), CKW'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvb_rr_merge.md
# mvb_rr_merge

Single-clock arbiter that shares one MVB datapath, typically the RX side of an MVB asynchronous FIFO, among several MVB producers. It grants whole MVB words from one input stream at a time in round-robin order. Each grant is limited to a configurable burst length. The merged stream leaves through one output register stage, tagged with the index of its source stream.

## Interface
- RX_STREAMS, 4, number of input MVB streams (2..16)
- MVB_ITEMS, 4, items per MVB word
- MVB_ITEM_WIDTH, 32, bits per item
- MAX_BURST, 4, maximum consecutive words taken from one stream before the grant rotates (1..256)

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; asynchronous, active-high
- RX_DATA  in  RX_STREAMS*MVB_ITEMS*MVB_ITEM_WIDTH  input words; stream i occupies slice i
- RX_VLD  in  RX_STREAMS*MVB_ITEMS  item valid bits per stream
- RX_SRC_RDY  in  RX_STREAMS  per-stream word valid
- RX_DST_RDY  out  RX_STREAMS  per-stream accept
- TX_DATA  out  MVB_ITEMS*MVB_ITEM_WIDTH  merged word
- TX_VLD  out  MVB_ITEMS  item valid bits
- TX_SRC_RDY  out  1  output word valid
- TX_DST_RDY  in  1  downstream accept
- TX_SEL  out  log2(RX_STREAMS)  source stream index of the current TX word

## Operation
- State: grant register G (stream index), burst counter C (0..MAX_BURST-1), output register (TX_DATA, TX_VLD, TX_SEL, TX_SRC_RDY).
- The output register can load when `load_ok = !TX_SRC_RDY or TX_DST_RDY`.
- RX_DST_RDY(i) = (G==i) and load_ok and not RESET. All other bits are 0. At most one bit is high at any time.
- Transfer from stream G when RX_SRC_RDY(G) and RX_DST_RDY(G).
  - If any RX_VLD bit of G is set, the word loads into the output register with TX_SEL=G and TX_SRC_RDY=1.
  - If all RX_VLD bits of G are 0, the word is consumed and dropped. It does not load, but it counts toward the burst.
- Output drain: if TX_DST_RDY is high and no new word loads, TX_SRC_RDY goes to 0.
- Grant rotation, evaluated each cycle:
  - Transfer and C==MAX_BURST-1: G moves to the next requesting stream searched from G+1 upward, wrapping, with G itself last. C is set to 0.
  - Transfer and C<MAX_BURST-1: C increments and G holds.
  - No transfer, RX_SRC_RDY(G)=0 and load_ok: G moves to the next requesting stream as above. C is set to 0. If no stream requests, G and C hold.
  - No transfer because load_ok=0 (backpressure): G and C hold. The grant never rotates while the granted stream is stalled.
- MAX_BURST=1 rotates after every word. C has width max(1, log2(MAX_BURST)).
- Item order within a word is preserved. Words from one stream stay in order. Words are never duplicated or split.

## Timing
- Reset values, applied asynchronously: TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_SEL=0, G=0, C=0, RX_DST_RDY=all 0.
- First cycle after reset release: RX_DST_RDY(0)=1.
- Latency: a word accepted in cycle n appears on TX in cycle n+1.
- Throughput: 1 word per cycle while G's stream keeps RX_SRC_RDY high and TX_DST_RDY is high.
- Switching cost:
  - Rotation on burst end costs no bubble, because the new G is already valid in the next cycle.
  - Rotation because G is idle costs exactly one idle cycle.
- TX holds stable (DATA, VLD, SEL, SRC_RDY) while TX_SRC_RDY=1 and TX_DST_RDY=0.
- RESET asserted mid-operation: the output word is discarded. The partner of an in-flight handshake sees RX_DST_RDY drop in the same cycle.

## Test plan
- Single stream: RX_STREAMS=4, MAX_BURST=4; stream 2 streams 10 words, others idle, TX_DST_RDY=1.
  - After reset G=0, so the grant takes one idle cycle to rotate to 2.
  - Then 10 words appear in order with TX_SEL=2 and 1 cycle latency.
  - Burst ends re-grant 2, since it is the only requester, with no bubbles.
- All four streams saturated, MAX_BURST=4, TX_DST_RDY=1 → TX_SEL sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0… with no idle cycles.
- Backpressure: all streams saturated, TX_DST_RDY toggled 1,0,0,1 repeating.
  - TX stays stable during stalls.
  - C advances only on transfers, so each stream still gets exactly 4 words per turn.
  - No word is lost or duplicated, checked by a scoreboard per stream.
- Empty words: stream 1 sends a word with RX_VLD=0000, then a word with RX_VLD=0101.
  - The first word is accepted and not forwarded.
  - The second appears with TX_VLD=0101 and TX_SEL=1.
  - Both count toward the burst.
- MAX_BURST=1, streams 0 and 3 saturated → TX_SEL alternates 0,3,0,3. Streams 1 and 2 never see RX_DST_RDY=1.
- Reset asserted while TX_SRC_RDY=1 and TX_DST_RDY=0 → TX_SRC_RDY=0 and RX_DST_RDY=0000 immediately. After release, G=0 and the next word accepted is from stream 0.
